player_shot_ctrl: RTL



---
 rtl/player_shot_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/player_shot_ctrl.sv
// Player shot initiator: tracks the aim lane, issues timed hit pulses on fire edges,
// and credits at most one enemy damage response per shot into a saturating score.
module player_shot_ctrl #(
  parameter int HIT_LEN  = 4,
  parameter int COOL_LEN = 16,
  parameter int POS_MAX  = 31,
  parameter int POS_RST  = 16,
  parameter int SCORE_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fire,
  input  logic               left,
  input  logic               right,
  input  logic               damage,
  output logic               hit,
  output logic [4:0]         pos,
  output logic               busy,
  output logic               shot_hit,
  output logic [SCORE_W-1:0] score
);

  localparam int CNT_MAX = (HIT_LEN > COOL_LEN) ? HIT_LEN : COOL_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX);

  typedef enum logic [1:0] {IDLE, FIRE, COOL} state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic             fire_q, left_q, right_q;
  logic             credited;

  logic       fire_rise, left_rise, right_rise;
  logic [4:0] pos_nxt;
  logic       in_window;

  assign fire_rise  = fire  & ~fire_q;
  assign left_rise  = left  & ~left_q;
  assign right_rise = right & ~right_q;

  // The enemy answers one cycle after sampling hit, so the first COOL cycle still counts.
  assign in_window = (state == FIRE) ||
                     ((state == COOL) && (counter == CNT_W'(COOL_LEN - 1)));

  always_comb begin
    pos_nxt = pos;
    if (left_rise && !right_rise && (pos != 5'd0))
      pos_nxt = pos - 5'd1;
    else if (right_rise && !left_rise && (pos != 5'(POS_MAX)))
      pos_nxt = pos + 5'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      counter  <= '0;
      fire_q   <= 1'b0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      credited <= 1'b0;
      hit      <= 1'b0;
      busy     <= 1'b0;
      shot_hit <= 1'b0;
      score    <= '0;
      pos      <= 5'(POS_RST);
    end else begin
      fire_q   <= fire;
      left_q   <= left;
      right_q  <= right;
      shot_hit <= 1'b0;

      if (in_window && damage && !credited) begin
        credited <= 1'b1;
        shot_hit <= 1'b1;
        if (score != '1)
          score <= score + 1'b1;
      end

      case (state)
        IDLE: begin
          if (fire_rise) begin
            state    <= FIRE;
            counter  <= CNT_W'(HIT_LEN - 1);
            credited <= 1'b0;
            hit      <= 1'b1;
            busy     <= 1'b1;
          end else begin
            pos <= pos_nxt;
          end
        end
        FIRE: begin
          if (counter == '0) begin
            state   <= COOL;
            counter <= CNT_W'(COOL_LEN - 1);
            hit     <= 1'b0;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        COOL: begin
          pos <= pos_nxt;
          if (counter == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
